// File: rtl/cpu_legv8_ts_pkg.sv
// Shared definitions for the single-cycle LEGv8 subset core:
// opcodes, ALU selectors, the decoded control bundle and the decoder itself.
package cpu_legv8_ts_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_e;
  typedef enum logic [1:0] {SRC_REG, SRC_IMM12, SRC_IMM9} alu_src_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    alu_src_e alu_src;
    alu_op_e  alu_op;
    logic     branch;
    logic     uncond;
    logic     cbnz;
    logic     mem_to_reg;
  } ctrl_t;

  // Unrecognised encodings fall out of the chain with every enable low, i.e. a NOP.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c.reg_write  = 1'b0;
    c.mem_read   = 1'b0;
    c.mem_write  = 1'b0;
    c.alu_src    = SRC_REG;
    c.alu_op     = ALU_ADD;
    c.branch     = 1'b0;
    c.uncond     = 1'b0;
    c.cbnz       = 1'b0;
    c.mem_to_reg = 1'b0;
    if (instr[31:21] == OP_ADD) begin
      c.reg_write = 1'b1;
    end else if (instr[31:21] == OP_SUB) begin
      c.reg_write = 1'b1;
      c.alu_op    = ALU_SUB;
    end else if (instr[31:21] == OP_AND) begin
      c.reg_write = 1'b1;
      c.alu_op    = ALU_AND;
    end else if (instr[31:21] == OP_ORR) begin
      c.reg_write = 1'b1;
      c.alu_op    = ALU_ORR;
    end else if (instr[31:21] == OP_LDUR) begin
      c.reg_write  = 1'b1;
      c.mem_read   = 1'b1;
      c.mem_to_reg = 1'b1;
      c.alu_src    = SRC_IMM9;
    end else if (instr[31:21] == OP_STUR) begin
      c.mem_write = 1'b1;
      c.alu_src   = SRC_IMM9;
    end else if (instr[31:22] == OP_ADDI) begin
      c.reg_write = 1'b1;
      c.alu_src   = SRC_IMM12;
    end else if (instr[31:22] == OP_SUBI) begin
      c.reg_write = 1'b1;
      c.alu_src   = SRC_IMM12;
      c.alu_op    = ALU_SUB;
    end else if (instr[31:24] == OP_CBZ) begin
      c.branch = 1'b1;
    end else if (instr[31:24] == OP_CBNZ) begin
      c.branch = 1'b1;
      c.cbnz   = 1'b1;
    end else if (instr[31:26] == OP_B) begin
      c.uncond = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/cpu_legv8_ts_if.sv
// Register-file access bundle: two async read ports, one sync write port, X0..X7 debug taps.
interface cpu_legv8_ts_if;
  logic [4:0]       rd_addr_a;
  logic [4:0]       rd_addr_b;
  logic [63:0]      rd_data_a;
  logic [63:0]      rd_data_b;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [63:0]      wr_data;
  logic [7:0][15:0] dbg;

  modport master (output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
                  input  rd_data_a, rd_data_b, dbg);
  modport slave  (input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
                  output rd_data_a, rd_data_b, dbg);
endinterface

// File: rtl/cpu_legv8_ts_regfile.sv
// 32x64 register file; X31 reads as zero and swallows writes, reset clears everything.
module cpu_legv8_ts_regfile (
  input  logic            clock,
  input  logic            rst_n,
  cpu_legv8_ts_if.slave   rf
);

  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (rf.wr_en && (rf.wr_addr != 5'd31)) begin
      regs_d[rf.wr_addr] = rf.wr_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rf.rd_data_a = (rf.rd_addr_a == 5'd31) ? 64'd0 : regs_q[rf.rd_addr_a];
  assign rf.rd_data_b = (rf.rd_addr_b == 5'd31) ? 64'd0 : regs_q[rf.rd_addr_b];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rf.dbg[i] = regs_q[i][15:0];
    end
  end

endmodule

// File: rtl/cpu_legv8_ts.sv
// Single-cycle LEGv8 subset CPU: ROM image supplied as a packed parameter, inline ALU and data RAM,
// shared tri-state data bus exposed for debug.
module cpu_legv8_ts
  import cpu_legv8_ts_pkg::*;
#(
  parameter int                      IMEM_WORDS = 64,
  parameter int                      DMEM_WORDS = 32,
  parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT = '0
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  output logic [31:0] address,
  output logic [31:0] instruction,
  output logic [15:0] r0,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [15:0] r3,
  output logic [15:0] r4,
  output logic [15:0] r5,
  output logic [15:0] r6,
  output logic [15:0] r7
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0]   pc_q, pc_d;
  logic [63:0]   ram_q [DMEM_WORDS];
  logic [IW-1:0] pc_idx;
  logic [DW-1:0] ram_idx;
  ctrl_t         ctrl;
  logic [63:0]   alu_b, alu_res, ram_rd, wb_data;
  logic [29:0]   br_off;
  logic          taken, bus_en;

  cpu_legv8_ts_if rf_if ();

  cpu_legv8_ts_regfile u_regfile (
    .clock (clock),
    .rst_n (reset),
    .rf    (rf_if.slave)
  );

  assign pc_idx      = pc_q[IW+1:2];
  assign instruction = IMEM_INIT[{pc_idx, 5'd0} +: 32];
  assign ctrl        = decode(instruction);

  // Stores and CBZ/CBNZ need Rt on the second read port instead of Rm.
  assign rf_if.rd_addr_a = instruction[9:5];
  assign rf_if.rd_addr_b = (ctrl.mem_write || ctrl.branch) ? instruction[4:0] : instruction[20:16];

  always_comb begin
    alu_b = rf_if.rd_data_b;
    case (ctrl.alu_src)
      SRC_IMM12: alu_b = {52'd0, instruction[21:10]};
      SRC_IMM9:  alu_b = {{55{instruction[20]}}, instruction[20:12]};
      default:   alu_b = rf_if.rd_data_b;
    endcase
    alu_res = rf_if.rd_data_a + alu_b;
    case (ctrl.alu_op)
      ALU_SUB: alu_res = rf_if.rd_data_a - alu_b;
      ALU_AND: alu_res = rf_if.rd_data_a & alu_b;
      ALU_ORR: alu_res = rf_if.rd_data_a | alu_b;
      default: alu_res = rf_if.rd_data_a + alu_b;
    endcase
  end

  assign address = alu_res[31:0];
  assign ram_idx = alu_res[DW+2:3];
  assign ram_rd  = ctrl.mem_read ? ram_q[ram_idx] : 64'd0;
  assign wb_data = ctrl.mem_to_reg ? ram_rd : alu_res;

  assign rf_if.wr_en   = ctrl.reg_write;
  assign rf_if.wr_addr = instruction[4:0];
  assign rf_if.wr_data = wb_data;

  always_comb begin
    br_off = ctrl.uncond ? {{4{instruction[25]}}, instruction[25:0]}
                         : {{11{instruction[23]}}, instruction[23:5]};
    taken  = ctrl.uncond ||
             (ctrl.branch && (ctrl.cbnz ? (rf_if.rd_data_b != 64'd0) : (rf_if.rd_data_b == 64'd0)));
    pc_d   = taken ? (pc_q + {br_off, 2'b00}) : (pc_q + 32'd4);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // RAM keeps its contents across reset; a store landing on a reset edge is dropped.
  always_ff @(posedge clock) begin
    if (reset && ctrl.mem_write) begin
      ram_q[ram_idx] <= rf_if.rd_data_b;
    end
  end

  assign bus_en = ctrl.reg_write || ctrl.mem_write;
  assign data   = bus_en ? (ctrl.mem_write ? rf_if.rd_data_b : wb_data) : 64'bz;

  assign r0 = rf_if.dbg[0];
  assign r1 = rf_if.dbg[1];
  assign r2 = rf_if.dbg[2];
  assign r3 = rf_if.dbg[3];
  assign r4 = rf_if.dbg[4];
  assign r5 = rf_if.dbg[5];
  assign r6 = rf_if.dbg[6];
  assign r7 = rf_if.dbg[7];

endmodule

// File: tb/tb_cpu_legv8_ts.sv
// Directed program run on cpu_legv8_ts; per-cycle expectations go through a scoreboard queue
// and are checked with immediate assertions on the falling clock edge.
module tb_cpu_legv8_ts;

  localparam int IMEM_WORDS = 64;
  localparam logic [63:0] BUS_Z = '1;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [9:0]  T_ADDI = 10'b1001000100;
  localparam logic [9:0]  T_SUBI = 10'b1101000100;
  localparam logic [7:0]  T_CBZ  = 8'b10110100;
  localparam logic [7:0]  T_CBNZ = 8'b10110101;

  function automatic logic [31:0] enc_r(logic [10:0] op, int rm, int rn, int rd);
    return {op, rm[4:0], 6'd0, rn[4:0], rd[4:0]};
  endfunction

  function automatic logic [31:0] enc_i(logic [9:0] op, int imm, int rn, int rd);
    return {op, imm[11:0], rn[4:0], rd[4:0]};
  endfunction

  function automatic logic [31:0] enc_d(logic [10:0] op, int imm, int rn, int rt);
    return {op, imm[8:0], 2'b00, rn[4:0], rt[4:0]};
  endfunction

  function automatic logic [31:0] enc_cb(logic [7:0] op, int off, int rt);
    return {op, off[18:0], rt[4:0]};
  endfunction

  function automatic logic [31:0] enc_b(int off);
    return {6'b000101, off[25:0]};
  endfunction

  function automatic logic [IMEM_WORDS*32-1:0] build_prog();
    logic [IMEM_WORDS*32-1:0] p;
    p = '0;
    p[0*32  +: 32] = enc_i(T_ADDI, 5, 31, 1);
    p[1*32  +: 32] = enc_i(T_ADDI, 3, 31, 2);
    p[2*32  +: 32] = enc_r(T_ADD, 2, 1, 3);
    p[3*32  +: 32] = enc_r(T_SUB, 2, 1, 4);
    p[4*32  +: 32] = enc_d(T_STUR, 16, 31, 3);
    p[5*32  +: 32] = enc_d(T_LDUR, 16, 31, 5);
    p[6*32  +: 32] = enc_b(1);
    p[7*32  +: 32] = enc_i(T_ADDI, 12, 31, 1);
    p[8*32  +: 32] = enc_i(T_ADDI, 10, 31, 2);
    p[9*32  +: 32] = enc_r(T_AND, 2, 1, 6);
    p[10*32 +: 32] = enc_r(T_ORR, 2, 1, 7);
    p[11*32 +: 32] = enc_r(T_ADD, 2, 1, 31);
    p[12*32 +: 32] = enc_r(T_ADD, 1, 31, 4);
    p[13*32 +: 32] = enc_cb(T_CBZ, 2, 0);
    p[14*32 +: 32] = enc_i(T_ADDI, 1, 31, 0);
    p[15*32 +: 32] = enc_cb(T_CBNZ, 2, 0);
    p[16*32 +: 32] = 32'h0000_0000;
    p[17*32 +: 32] = enc_i(T_ADDI, 7, 31, 0);
    p[18*32 +: 32] = enc_cb(T_CBNZ, 2, 0);
    p[19*32 +: 32] = enc_i(T_ADDI, 99, 31, 6);
    p[20*32 +: 32] = enc_b(3);
    p[21*32 +: 32] = enc_i(T_SUBI, 3, 7, 6);
    p[22*32 +: 32] = enc_b(2);
    p[23*32 +: 32] = enc_b(-2);
    p[24*32 +: 32] = enc_b(0);
    return p;
  endfunction

  localparam logic [IMEM_WORDS*32-1:0] PROG = build_prog();

  typedef struct {
    int          step;
    logic [31:0] instr;
    bit          chk_data;
    logic [63:0] data;
    bit          chk_addr;
    logic [31:0] addr;
    int          reg_idx;
    logic [15:0] reg_val;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  wire  [63:0] data;
  logic [31:0] address, instruction;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Released bus floats high so a tri-stated cycle reads as all ones.
  pullup (data);

  always #5 clock = ~clock;

  cpu_legv8_ts #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (32),
    .IMEM_INIT  (PROG)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .data        (data),
    .address     (address),
    .instruction (instruction),
    .r0 (r0), .r1 (r1), .r2 (r2), .r3 (r3),
    .r4 (r4), .r5 (r5), .r6 (r6), .r7 (r7)
  );

  function automatic logic [31:0] word(int i);
    return PROG[i*32 +: 32];
  endfunction

  function automatic logic [15:0] reg_view(int i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      4: return r4;
      5: return r5;
      6: return r6;
      default: return r7;
    endcase
  endfunction

  task automatic check_output();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=>0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (instruction === e.instr) else begin
        errors++;
        $error("FAIL step%0d_instr observed=%h expected=%h", e.step, instruction, e.instr);
      end
      if (e.chk_data) begin
        checks++;
        assert (data === e.data) else begin
          errors++;
          $error("FAIL step%0d_data observed=%h expected=%h", e.step, data, e.data);
        end
      end
      if (e.chk_addr) begin
        checks++;
        assert (address === e.addr) else begin
          errors++;
          $error("FAIL step%0d_addr observed=%h expected=%h", e.step, address, e.addr);
        end
      end
      if (e.reg_idx >= 0) begin
        checks++;
        assert (reg_view(e.reg_idx) === e.reg_val) else begin
          errors++;
          $error("FAIL step%0d_r%0d observed=%h expected=%h", e.step, e.reg_idx,
                 reg_view(e.reg_idx), e.reg_val);
        end
      end
    end
  endtask

  task automatic apply_stimulus(int wi, bit chk_data, logic [63:0] d, bit chk_addr,
                                logic [31:0] a, int ridx, logic [15:0] rv);
    exp_t e;
    e.step = step_no;
    e.instr = word(wi);
    e.chk_data = chk_data;
    e.data = d;
    e.chk_addr = chk_addr;
    e.addr = a;
    e.reg_idx = ridx;
    e.reg_val = rv;
    sb.push_back(e);
    check_output();
    step_no++;
    @(negedge clock);
  endtask

  initial begin
    $display("[TB] start");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 1'b0, '0, 1'b0, '0, i, 16'h0);
    end
    reset = 1'b1;

    apply_stimulus(0,  1, 64'd5,    1, 32'd5,    1, 16'd0);
    apply_stimulus(1,  1, 64'd3,    0, '0,       1, 16'd5);
    apply_stimulus(2,  1, 64'd8,    1, 32'd8,    2, 16'd3);
    apply_stimulus(3,  1, 64'd2,    0, '0,       3, 16'd8);
    apply_stimulus(4,  1, 64'd8,    1, 32'd16,   4, 16'd2);
    apply_stimulus(5,  1, 64'd8,    1, 32'd16,   5, 16'd0);
    apply_stimulus(6,  1, BUS_Z,    0, '0,       5, 16'd8);
    apply_stimulus(7,  1, 64'd12,   0, '0,       1, 16'd5);
    apply_stimulus(8,  1, 64'd10,   0, '0,       1, 16'd12);
    apply_stimulus(9,  1, 64'h8,    0, '0,       2, 16'd10);
    apply_stimulus(10, 1, 64'hE,    0, '0,       6, 16'h8);
    apply_stimulus(11, 1, 64'h16,   1, 32'h16,   7, 16'hE);
    apply_stimulus(12, 1, 64'd12,   0, '0,       4, 16'd2);
    apply_stimulus(13, 1, BUS_Z,    0, '0,       4, 16'd12);
    apply_stimulus(15, 1, BUS_Z,    0, '0,       0, 16'd0);
    apply_stimulus(16, 1, BUS_Z,    0, '0,       0, 16'd0);
    apply_stimulus(17, 1, 64'd7,    0, '0,       7, 16'hE);
    apply_stimulus(18, 1, BUS_Z,    0, '0,       0, 16'd7);
    apply_stimulus(20, 1, BUS_Z,    0, '0,       6, 16'h8);
    apply_stimulus(23, 1, BUS_Z,    0, '0,       6, 16'h8);
    apply_stimulus(21, 1, 64'hB,    0, '0,       6, 16'h8);
    apply_stimulus(22, 1, BUS_Z,    0, '0,       6, 16'hB);
    apply_stimulus(24, 1, BUS_Z,    0, '0,       6, 16'hB);
    apply_stimulus(24, 1, BUS_Z,    0, '0,       7, 16'hE);
    apply_stimulus(24, 1, BUS_Z,    0, '0,       3, 16'd8);

    // Mid-run reset: takes effect between edges, and holds through a rising edge.
    #2 reset = 1'b0;
    #1;
    sb.push_back('{step: step_no, instr: word(0), chk_data: 1'b0, data: '0,
                   chk_addr: 1'b0, addr: '0, reg_idx: 1, reg_val: 16'd0});
    check_output();
    step_no++;
    @(negedge clock);
    apply_stimulus(0, 0, '0, 0, '0, 5, 16'd0);
    reset = 1'b1;
    apply_stimulus(0, 1, 64'd5, 1, 32'd5, 3, 16'd0);
    apply_stimulus(1, 1, 64'd3, 0, '0,    1, 16'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
